bootram_arbiter: RTL and testbench

- Shares the single read port of the 512 B boot RAM between two requesters: port 0 for instruction fetch and port 1 for data load.
- The boot RAM registers its word address on the clock edge and presents read data combinationally from that registered address.
- This block selects which address reaches the RAM each cycle and routes the returned word back to the owning requester.
- It holds the RAM address stable while a response is stalled and flags out-of-range or misaligned accesses.

---
 rtl/bootram_arbiter.sv | 100 ++++++++++
 tb/tb_bootram_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bootram_arbiter.sv
// Two-port read arbiter for the boot RAM: instruction fetch (port 0) and data load (port 1).
// Grants are combinational; one response is tracked and held stable until its owner accepts it.
module bootram_arbiter #(
  parameter int unsigned MEM_BYTES = 512,
  parameter bit          FIX_PRIO  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic [31:0] p0_addr,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_rerr,
  input  logic        p0_rready,
  input  logic        p1_req,
  input  logic [31:0] p1_addr,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_rerr,
  input  logic        p1_rready,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rd_data
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  logic        pending;
  logic        owner;
  logic        last_winner;
  logic [31:0] last_addr;
  logic        last_err;

  logic        owner_rready;
  logic        accept;
  logic        can_issue;
  logic        grant;
  logic        winner;
  logic [31:0] win_addr;
  logic        win_err;

  assign owner_rready = owner ? p1_rready : p0_rready;
  assign accept       = pending & owner_rready;
  assign can_issue    = ~pending | accept;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    grant  = 1'b0;
    winner = 1'b0;
    // Grants are masked while reset is asserted so mem_addr falls back to the cleared last_addr.
    if (rst_n && can_issue) begin
      if (p0_req && p1_req) begin
        grant  = 1'b1;
        winner = FIX_PRIO ? 1'b0 : ~last_winner;
      end else if (p0_req) begin
        grant  = 1'b1;
        winner = 1'b0;
      end else if (p1_req) begin
        grant  = 1'b1;
        winner = 1'b1;
      end
    end
  end

  assign win_addr = winner ? p1_addr : p0_addr;
  assign win_err  = (win_addr[1:0] != 2'b00) | (win_addr >= MEM_LIMIT);

  assign p0_gnt   = grant & ~winner;
  assign p1_gnt   = grant & winner;
  // Re-presenting last_addr keeps the RAM's registered address, and thus its data, frozen in a stall.
  assign mem_addr = grant ? win_addr : last_addr;

  assign p0_rvalid = pending & ~owner;
  assign p1_rvalid = pending & owner;
  assign p0_rerr   = p0_rvalid & last_err;
  assign p1_rerr   = p1_rvalid & last_err;
  assign p0_rdata  = (p0_rvalid && !last_err) ? mem_rd_data : 32'h0;
  assign p1_rdata  = (p1_rvalid && !last_err) ? mem_rd_data : 32'h0;

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= 1'b0;
      owner       <= 1'b0;
      last_winner <= 1'b1;
      last_addr   <= 32'h0;
      last_err    <= 1'b0;
    end else if (grant) begin
      pending     <= 1'b1;
      owner       <= winner;
      last_winner <= winner;
      last_addr   <= win_addr;
      last_err    <= win_err;
    end else if (accept) begin
      pending     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bootram_arbiter.sv
// Directed bench for bootram_arbiter: round-robin and fixed-priority instances share stimulus
// and each sees its own behavioural boot RAM with a registered address.
module tb_bootram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p1_req, p0_rready, p1_rready;
  logic [31:0] p0_addr, p1_addr;

  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rerr, p1_rerr;
  logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_rd_data;

  logic        f0_gnt, f1_gnt, f0_rvalid, f1_rvalid, f0_rerr, f1_rerr;
  logic [31:0] f0_rdata, f1_rdata, f_mem_addr, f_mem_rd_data;

  logic [31:0] ram [128];
  logic [31:0] ram_q, f_ram_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bootram_arbiter #(.MEM_BYTES(512), .FIX_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_rerr(p0_rerr), .p0_rready(p0_rready),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_rerr(p1_rerr), .p1_rready(p1_rready),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data)
  );

  bootram_arbiter #(.MEM_BYTES(512), .FIX_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(f0_gnt), .p0_rvalid(f0_rvalid),
    .p0_rdata(f0_rdata), .p0_rerr(f0_rerr), .p0_rready(p0_rready),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_gnt(f1_gnt), .p1_rvalid(f1_rvalid),
    .p1_rdata(f1_rdata), .p1_rerr(f1_rerr), .p1_rready(p1_rready),
    .mem_addr(f_mem_addr), .mem_rd_data(f_mem_rd_data)
  );

  // Boot RAM model: address registered on the edge, data read combinationally; index wraps.
  always @(posedge clk) begin
    ram_q   <= mem_addr;
    f_ram_q <= f_mem_addr;
  end
  assign mem_rd_data   = ram[ram_q[8:2]];
  assign f_mem_rd_data = ram[f_ram_q[8:2]];

  function automatic logic [31:0] exp_word(int idx);
    return (idx == 4) ? 32'hDEAD_BEEF : (32'hA500_0000 + 32'(idx));
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    p0_req = 1'b0; p1_req = 1'b0;
    p0_addr = 32'h0; p1_addr = 32'h0;
    p0_rready = 1'b1; p1_rready = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ram[i] = exp_word(i);
    ram_q = 32'h0;
    f_ram_q = 32'h0;
    do_reset();

    // Reset state
    sample();
    check("rst_p0_gnt", 32'(p0_gnt), 32'd0);
    check("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
    check("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);

    // Single read, latency 1
    tick();
    p0_req = 1'b1; p0_addr = 32'h10;
    sample();
    check("single_gnt", 32'(p0_gnt), 32'd1);
    check("single_p1_gnt", 32'(p1_gnt), 32'd0);
    check("single_mem_addr", mem_addr, 32'h10);
    tick();
    p0_req = 1'b0;
    sample();
    check("single_rvalid", 32'(p0_rvalid), 32'd1);
    check("single_rdata", p0_rdata, 32'hDEAD_BEEF);
    check("single_rerr", 32'(p0_rerr), 32'd0);
    tick();

    // Contention: round-robin alternates from p0; fixed priority always p0
    do_reset();
    p0_req = 1'b1; p0_addr = 32'h40;
    p1_req = 1'b1; p1_addr = 32'h80;
    for (int i = 0; i < 4; i++) begin
      sample();
      check($sformatf("rr_p0_gnt%0d", i), 32'(p0_gnt), 32'((i % 2) == 0));
      check($sformatf("rr_p1_gnt%0d", i), 32'(p1_gnt), 32'((i % 2) == 1));
      check($sformatf("fp_p0_gnt%0d", i), 32'(f0_gnt), 32'd1);
      check($sformatf("fp_p1_gnt%0d", i), 32'(f1_gnt), 32'd0);
      if (i > 0) begin
        check($sformatf("rr_p0_rvalid%0d", i), 32'(p0_rvalid), 32'((i % 2) == 1));
        check($sformatf("rr_p1_rvalid%0d", i), 32'(p1_rvalid), 32'((i % 2) == 0));
        check($sformatf("rr_rdata%0d", i), (i % 2) ? p0_rdata : p1_rdata,
              (i % 2) ? exp_word(16) : exp_word(32));
        check($sformatf("fp_rdata%0d", i), f0_rdata, exp_word(16));
      end
      tick();
    end
    p0_req = 1'b0; p1_req = 1'b0;
    sample();
    check("rr_last_p1_rvalid", 32'(p1_rvalid), 32'd1);
    check("rr_last_p1_rdata", p1_rdata, exp_word(32));
    tick();

    // Stall: p0 holds off its response, p1 waits, then is granted on the accepting cycle
    p0_req = 1'b1; p0_addr = 32'h20; p0_rready = 1'b0;
    p1_req = 1'b1; p1_addr = 32'h30;
    sample();
    check("stall_p0_gnt", 32'(p0_gnt), 32'd1);
    check("stall_grant_mem_addr", mem_addr, 32'h20);
    tick();
    p0_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check($sformatf("stall_rvalid%0d", i), 32'(p0_rvalid), 32'd1);
      check($sformatf("stall_rdata%0d", i), p0_rdata, exp_word(8));
      check($sformatf("stall_mem_addr%0d", i), mem_addr, 32'h20);
      check($sformatf("stall_p1_gnt%0d", i), 32'(p1_gnt), 32'd0);
      tick();
    end
    p0_rready = 1'b1;
    sample();
    check("release_p1_gnt", 32'(p1_gnt), 32'd1);
    check("release_p0_rvalid", 32'(p0_rvalid), 32'd1);
    check("release_mem_addr", mem_addr, 32'h30);
    tick();
    p1_req = 1'b0;
    sample();
    check("release_p1_rvalid", 32'(p1_rvalid), 32'd1);
    check("release_p1_rdata", p1_rdata, exp_word(12));
    check("release_p0_rvalid_low", 32'(p0_rvalid), 32'd0);
    tick();

    // Error accesses back-to-back, then a legal one
    p0_req = 1'b1; p0_addr = 32'h200;
    sample();
    check("err_oor_gnt", 32'(p0_gnt), 32'd1);
    tick();
    p0_addr = 32'h6;
    sample();
    check("err_oor_rerr", 32'(p0_rerr), 32'd1);
    check("err_oor_rdata", p0_rdata, 32'h0);
    check("err_mis_gnt", 32'(p0_gnt), 32'd1);
    tick();
    p0_addr = 32'h10;
    sample();
    check("err_mis_rvalid", 32'(p0_rvalid), 32'd1);
    check("err_mis_rerr", 32'(p0_rerr), 32'd1);
    check("err_mis_rdata", p0_rdata, 32'h0);
    check("err_legal_gnt", 32'(p0_gnt), 32'd1);
    tick();
    p0_req = 1'b0;
    sample();
    check("err_legal_rerr", 32'(p0_rerr), 32'd0);
    check("err_legal_rdata", p0_rdata, 32'hDEAD_BEEF);
    tick();

    // Asynchronous reset during a stall
    p0_req = 1'b1; p0_addr = 32'h24; p0_rready = 1'b0;
    sample();
    check("ar_gnt", 32'(p0_gnt), 32'd1);
    tick();
    p0_req = 1'b1; p1_req = 1'b1; p1_addr = 32'h28;
    sample();
    check("ar_stalled_rvalid", 32'(p0_rvalid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_rvalid_zero", 32'(p0_rvalid), 32'd0);
    check("ar_p0_gnt_zero", 32'(p0_gnt), 32'd0);
    check("ar_p1_gnt_zero", 32'(p1_gnt), 32'd0);
    check("ar_mem_addr_zero", mem_addr, 32'h0);
    check("ar_rdata_zero", p0_rdata, 32'h0);
    tick();
    idle_inputs();
    p0_rready = 1'b0;
    rst_n = 1'b1;
    sample();
    check("ar_post_p0_rvalid", 32'(p0_rvalid), 32'd0);
    check("ar_post_p1_rvalid", 32'(p1_rvalid), 32'd0);
    tick();
    p0_req = 1'b1; p0_addr = 32'h24;
    p1_req = 1'b1; p1_addr = 32'h28;
    sample();
    check("ar_first_p0_gnt", 32'(p0_gnt), 32'd1);
    check("ar_first_p1_gnt", 32'(p1_gnt), 32'd0);
    tick();
    p0_req = 1'b0; p1_req = 1'b0;
    sample();
    check("ar_first_rvalid", 32'(p0_rvalid), 32'd1);
    check("ar_first_rdata", p0_rdata, exp_word(9));
    check("ar_first_p1_rvalid", 32'(p1_rvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
